// File: rtl/decode_stage.sv
// Instruction decode: flag-table lookup per opcode, decoded ops queued in a small FIFO.
// Latency 1 cycle from input acceptance to out_valid; in_ready depends on fill level only.
// Backpressure: the buffer holds ops while out_ready=0; input stalls when DEPTH entries are queued.

module decode_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wr_dat,
    output logic [W-1:0]               rd_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rd_dat = mem[rd_ptr];
endmodule

module decode_stage #(
    parameter int OPC_W  = 4,
    parameter int IDX_W  = 4,
    parameter int FLAG_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [OPC_W+3*IDX_W-1:0]    in_instr,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [1:0][IDX_W:0]         out_readregs,
    output logic [IDX_W:0]              out_writereg,
    output logic [7:0]                  out_flagouts,
    output logic [3:0]                  out_fuid,
    output logic                        out_illegal,
    input  logic                        cfg_we,
    input  logic [OPC_W-1:0]            cfg_addr,
    input  logic [FLAG_W-1:0]           cfg_data,
    input  logic                        flush,
    output logic [15:0]                 illegal_cnt
);
    localparam int INSTR_W = OPC_W + 3*IDX_W;
    localparam int RW      = IDX_W + 1;
    localparam int CW      = $clog2(DEPTH+1);
    localparam int NENT    = 1 << OPC_W;

    typedef struct packed {
        logic [1:0][RW-1:0] readregs;
        logic [RW-1:0]      writereg;
        logic [7:0]         flagouts;
        logic [3:0]         fuid;
        logic               illegal;
    } op_t;

    logic [FLAG_W-1:0] flag_table [NENT];
    logic [IDX_W-1:0]  fa, fb, fc;
    logic [OPC_W-1:0]  opcode;
    logic [FLAG_W-1:0] flags;
    logic [CW-1:0]     count;
    logic              accept, push, pop;
    op_t               dec, head;

    assign fa     = in_instr[INSTR_W-1 -: IDX_W];
    assign fb     = in_instr[INSTR_W-IDX_W-1 -: IDX_W];
    assign fc     = in_instr[INSTR_W-2*IDX_W-1 -: IDX_W];
    assign opcode = in_instr[OPC_W-1:0];
    // Registered table: a same-cycle cfg write lands at the edge, so this read sees the old entry.
    assign flags  = flag_table[opcode];

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !flush;
    assign pop       = out_valid && out_ready;

    always_comb begin
        dec = '0;
        if (flags[0])      dec.writereg = {fa, 1'b1};
        else if (flags[1]) dec.writereg = {fc, 1'b1};
        if (flags[2])      dec.readregs[0] = {fa, 1'b1};
        if (flags[3])      dec.readregs[1] = {fb, 1'b1};
        dec.flagouts = flags[15:8];
        dec.fuid     = flags[7:4];
        dec.illegal  = (flags == '0) && (opcode != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++)
                flag_table[i] <= (i == 1) ? FLAG_W'(16'h000E) : '0;
        end else if (cfg_we) begin
            flag_table[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt <= '0;
        else if (push && dec.illegal && (illegal_cnt != 16'hFFFF))
            illegal_cnt <= illegal_cnt + 16'd1;
    end

    decode_fifo #(.W($bits(op_t)), .DEPTH(DEPTH)) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .push   (push),
        .pop    (pop),
        .wr_dat (dec),
        .rd_dat (head),
        .count  (count)
    );

    assign out_readregs = head.readregs;
    assign out_writereg = head.writereg;
    assign out_flagouts = head.flagouts;
    assign out_fuid     = head.fuid;
    assign out_illegal  = head.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: constant vector table, hand sequences for stall/flush/saturation/reset,
// and a negedge monitor with an expected-op queue checking order, handshakes and illegal_cnt.
module tb_decode_stage;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [15:0]      in_instr;
    logic [1:0][4:0]  out_readregs;
    logic [4:0]       out_writereg;
    logic [7:0]       out_flagouts;
    logic [3:0]       out_fuid;
    logic             out_illegal;
    logic             cfg_we;
    logic [3:0]       cfg_addr;
    logic [15:0]      cfg_data;
    logic             flush;
    logic [15:0]      illegal_cnt;

    decode_stage #(.OPC_W(4), .IDX_W(4), .FLAG_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_readregs(out_readregs), .out_writereg(out_writereg),
        .out_flagouts(out_flagouts), .out_fuid(out_fuid), .out_illegal(out_illegal),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .flush(flush), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] wr, rr0, rr1;
        logic [7:0] fl;
        logic [3:0] fu;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [15:0] instr;
        logic        cfg_we;
        logic [3:0]  cfg_addr;
        logic [15:0] cfg_data;
        exp_t        e;
        logic [15:0] cnt;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    exp_t        q[$];
    logic [15:0] mtab [16];
    logic [15:0] exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] ins);
        exp_t        r;
        logic [15:0] f;
        f     = mtab[ins[3:0]];
        r.wr  = f[0] ? {ins[15:12], 1'b1} : (f[1] ? {ins[7:4], 1'b1} : 5'd0);
        r.rr0 = f[2] ? {ins[15:12], 1'b1} : 5'd0;
        r.rr1 = f[3] ? {ins[11:8], 1'b1} : 5'd0;
        r.fl  = f[15:8];
        r.fu  = f[7:4];
        r.ill = (f == 16'h0) && (ins[3:0] != 4'h0);
        return r;
    endfunction

    // Monitor: handshakes are stable between posedges, so negedge sees what the next edge acts on.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            exp_cnt = 16'h0;
            for (int i = 0; i < 16; i++) mtab[i] = (i == 1) ? 16'h000E : 16'h0;
        end else begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
            chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            chk("illegal_cnt", {16'b0, illegal_cnt}, {16'b0, exp_cnt});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("pop_nonempty", 32'd0, 32'd1);
                end else begin
                    e = q.pop_front();
                    pops++;
                    chk("sb_writereg", {27'b0, out_writereg}, {27'b0, e.wr});
                    chk("sb_readreg0", {27'b0, out_readregs[0]}, {27'b0, e.rr0});
                    chk("sb_readreg1", {27'b0, out_readregs[1]}, {27'b0, e.rr1});
                    chk("sb_flagouts", {24'b0, out_flagouts}, {24'b0, e.fl});
                    chk("sb_fuid", {28'b0, out_fuid}, {28'b0, e.fu});
                    chk("sb_illegal", {31'b0, out_illegal}, {31'b0, e.ill});
                end
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                e = model(in_instr);
                q.push_back(e);
                if (e.ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
            if (cfg_we) mtab[cfg_addr] = cfg_data;
        end
    end

    // Called and returns just after a posedge; holds in_valid until the instruction is taken.
    task automatic send(input logic [15:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
        chk("drain_empty", q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[9];
    int   pops0;

    initial begin
        vecs[0] = '{16'h1231, 1'b0, 4'h0, 16'h0000, '{5'd7,  5'd3, 5'd5, 8'h00, 4'h0, 1'b0}, 16'd0};
        vecs[1] = '{16'h0000, 1'b1, 4'h2, 16'hA5F1, '{5'd0,  5'd0, 5'd0, 8'h00, 4'h0, 1'b0}, 16'd0};
        vecs[2] = '{16'h4562, 1'b0, 4'h0, 16'h0000, '{5'd9,  5'd0, 5'd0, 8'hA5, 4'hF, 1'b0}, 16'd0};
        vecs[3] = '{16'h0003, 1'b0, 4'h0, 16'h0000, '{5'd0,  5'd0, 5'd0, 8'h00, 4'h0, 1'b1}, 16'd1};
        vecs[4] = '{16'h1231, 1'b1, 4'h1, 16'h3C25, '{5'd7,  5'd3, 5'd5, 8'h00, 4'h0, 1'b0}, 16'd1};
        vecs[5] = '{16'h1231, 1'b0, 4'h0, 16'h0000, '{5'd3,  5'd3, 5'd0, 8'h3C, 4'h2, 1'b0}, 16'd1};
        vecs[6] = '{16'hABC0, 1'b0, 4'h0, 16'h0000, '{5'd0,  5'd0, 5'd0, 8'h00, 4'h0, 1'b0}, 16'd1};
        vecs[7] = '{16'h9875, 1'b1, 4'h5, 16'h0002, '{5'd0,  5'd0, 5'd0, 8'h00, 4'h0, 1'b1}, 16'd2};
        vecs[8] = '{16'h9875, 1'b0, 4'h0, 16'h0000, '{5'd15, 5'd0, 5'd0, 8'h00, 4'h0, 1'b0}, 16'd2};

        rst_n = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_illegal_cnt", {16'b0, illegal_cnt}, 32'd0);
        chk("rst_writereg", {27'b0, out_writereg}, 32'd0);
        chk("rst_readregs", {22'b0, out_readregs}, 32'd0);
        chk("rst_flagouts", {24'b0, out_flagouts}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            cfg_we = vecs[i].cfg_we; cfg_addr = vecs[i].cfg_addr; cfg_data = vecs[i].cfg_data;
            send(vecs[i].instr);
            cfg_we = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("v%0d_writereg", i), {27'b0, out_writereg}, {27'b0, vecs[i].e.wr});
            chk($sformatf("v%0d_readreg0", i), {27'b0, out_readregs[0]}, {27'b0, vecs[i].e.rr0});
            chk($sformatf("v%0d_readreg1", i), {27'b0, out_readregs[1]}, {27'b0, vecs[i].e.rr1});
            chk($sformatf("v%0d_flagouts", i), {24'b0, out_flagouts}, {24'b0, vecs[i].e.fl});
            chk($sformatf("v%0d_fuid", i), {28'b0, out_fuid}, {28'b0, vecs[i].e.fu});
            chk($sformatf("v%0d_illegal", i), {31'b0, out_illegal}, {31'b0, vecs[i].e.ill});
            chk($sformatf("v%0d_cnt", i), {16'b0, illegal_cnt}, {16'b0, vecs[i].cnt});
            @(posedge clk); #1;
        end

        // Stall: two ops fill the buffer, the third waits, head fields stay put.
        pops0 = pops;
        out_ready = 1'b0;
        send(16'h1232);
        send(16'h4562);
        in_valid = 1'b1; in_instr = 16'h7892;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_writereg", {27'b0, out_writereg}, 32'd3);
            chk("stall_flagouts", {24'b0, out_flagouts}, 32'hA5);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(16'h7892);
        drain();
        chk("stall_pops", pops - pops0, 32'd3);

        // Flush while full with an input offered.
        out_ready = 1'b0;
        send(16'h1232);
        send(16'h4562);
        in_valid = 1'b1; in_instr = 16'h0007; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_full_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_full_ready", {31'b0, in_ready}, 32'd1);
        // Flush with an illegal op actually accepted in the same cycle.
        @(posedge clk); #1;
        send(16'h1232);
        in_valid = 1'b1; in_instr = 16'h0007; flush = 1'b1;
        @(negedge clk);
        chk("flush_acc_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_acc_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_acc_cnt", {16'b0, illegal_cnt}, 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'h7892);
        @(negedge clk);
        chk("post_flush_writereg", {27'b0, out_writereg}, 32'd15);
        @(posedge clk); #1;
        drain();

        // Saturation of illegal_cnt under continuous streaming.
        in_valid = 1'b1; in_instr = 16'h0003;
        for (int k = 0; k < 70000 && exp_cnt != 16'hFFFF; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("sat_cnt", {16'b0, illegal_cnt}, 32'hFFFF);
        @(posedge clk); #1;
        drain();

        // Reset mid-operation drops buffered ops and restores the table.
        out_ready = 1'b0;
        cfg_we = 1'b1; cfg_addr = 4'h1; cfg_data = 16'h0001;
        send(16'h1232);
        cfg_we = 1'b0;
        send(16'h4562);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_cnt", {16'b0, illegal_cnt}, 32'd0);
        chk("mid_rst_writereg", {27'b0, out_writereg}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(16'h1231);
        @(negedge clk);
        chk("post_rst_writereg", {27'b0, out_writereg}, 32'd7);
        chk("post_rst_readreg1", {27'b0, out_readregs[1]}, 32'd5);
        @(posedge clk); #1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
